cpu_sequencer: RTL and testbench

Multi-cycle control sequencer for the 16-bit CPU.
- Steps each instruction through fetch, decode, execute, memory and write-back.
- Shares the single unified memory port between instruction fetch and LW/SW data access.
- Drives the register-file, ALU, PC and IR enables that the single-cycle decoder previously produced in one combinational step.

---
 rtl/cpu_sequencer_if.sv | 39 +++
 rtl/cpu_sequencer.sv | 164 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
`default_nettype none
// ============================================================================
// cpu_sequencer_if : opcode/flag inputs, memory handshake and datapath enables
//                    between the control sequencer and the 16-bit CPU datapath.
// Rev 1.0
// ============================================================================
interface cpu_sequencer_if;
  logic [3:0] Opcode;
  logic       Zero;
  logic       MemReady;
  logic       MemReq;
  logic       MemWrite;
  logic       IorD;
  logic       IRWrite;
  logic       PCWrite;
  logic       PCSrc;
  logic       RegWrite;
  logic       RegDst;
  logic       MemToReg;
  logic       AluSrc;
  logic [1:0] ALUOp;
  logic       InstrDone;
  logic       IllegalOp;
  logic       Halted;
  logic [2:0] State;

  modport master (
    input  Opcode, Zero, MemReady,
    output MemReq, MemWrite, IorD, IRWrite, PCWrite, PCSrc, RegWrite, RegDst,
           MemToReg, AluSrc, ALUOp, InstrDone, IllegalOp, Halted, State
  );

  modport slave (
    output Opcode, Zero, MemReady,
    input  MemReq, MemWrite, IorD, IRWrite, PCWrite, PCSrc, RegWrite, RegDst,
           MemToReg, AluSrc, ALUOp, InstrDone, IllegalOp, Halted, State
  );
endinterface
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// cpu_sequencer : multi-cycle FETCH/DECODE/EXEC/MEM/WB control for the 16-bit
//                 CPU; macro CPU_SEQ_HALT_EN makes opcode 1110 a terminal HALT.
// Rev 1.0
// ============================================================================
module cpu_sequencer (
  input wire              clk,
  input wire              reset,
  cpu_sequencer_if.master bus
);

`ifdef CPU_SEQ_HALT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_HALT = 4'b1110;
  localparam logic [3:0] OP_BEQ  = 4'b1111;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t     state;
  logic [3:0] op_reg;
  logic [1:0] exec_aluop;
  logic       exec_alusrc;

  function automatic logic is_rtype(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0010, 4'b0011, 4'b0100,
      4'b0110, 4'b0111, 4'b1100: is_rtype = 1'b1;
      default:                   is_rtype = 1'b0;
    endcase
  endfunction

  function automatic logic is_itype(input logic [3:0] op);
    is_itype = (op == 4'b0001) || (op == 4'b0101) || (op == 4'b1101);
  endfunction

  function automatic logic is_defined(input logic [3:0] op);
    is_defined = is_rtype(op) || is_itype(op) || (op == OP_LW) ||
                 (op == OP_SW) || (op == OP_BEQ);
  endfunction

  function automatic logic is_halt(input logic [3:0] op);
    is_halt = HALT_EN && (op == OP_HALT);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_INIT;
      op_reg <= 4'd0;
    end else begin
      case (state)
        S_INIT:  state <= S_FETCH;
        S_FETCH: if (bus.MemReady) state <= S_DECODE;
        S_DECODE: begin
          op_reg <= bus.Opcode;
          if (is_defined(bus.Opcode))   state <= S_EXEC;
          else if (is_halt(bus.Opcode)) state <= S_HALT;
          else                          state <= S_FETCH;
        end
        S_EXEC: begin
          if (is_rtype(op_reg) || is_itype(op_reg))       state <= S_WB;
          else if ((op_reg == OP_LW) || (op_reg == OP_SW)) state <= S_MEM;
          else                                             state <= S_FETCH;
        end
        S_MEM:   if (bus.MemReady) state <= (op_reg == OP_LW) ? S_WB : S_FETCH;
        S_WB:    state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        default: state <= S_INIT;
      endcase
    end
  end

  // ALU controls chosen in EXEC are repeated in MEM/WB so ALUOut stays stable.
  always_comb begin
    exec_aluop  = 2'b00;
    exec_alusrc = 1'b0;
    if (is_rtype(op_reg)) begin
      exec_aluop = 2'b10;
    end else if (is_itype(op_reg)) begin
      exec_aluop  = 2'b11;
      exec_alusrc = 1'b1;
    end else if (op_reg == OP_BEQ) begin
      exec_aluop = 2'b01;
    end else if ((op_reg == OP_LW) || (op_reg == OP_SW)) begin
      exec_alusrc = 1'b1;
    end
  end

  always_comb begin
    bus.MemReq    = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.IorD      = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.PCWrite   = 1'b0;
    bus.PCSrc     = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.RegDst    = 1'b0;
    bus.MemToReg  = 1'b0;
    bus.AluSrc    = 1'b0;
    bus.ALUOp     = 2'b00;
    bus.InstrDone = 1'b0;
    bus.IllegalOp = 1'b0;
    bus.Halted    = 1'b0;
    bus.State     = state;
    case (state)
      S_FETCH: begin
        bus.MemReq  = 1'b1;
        bus.IRWrite = bus.MemReady;
        bus.PCWrite = bus.MemReady;
      end
      S_DECODE: begin
        if (is_halt(bus.Opcode)) begin
          bus.InstrDone = 1'b1;
        end else if (!is_defined(bus.Opcode)) begin
          bus.IllegalOp = 1'b1;
          bus.InstrDone = 1'b1;
        end
      end
      S_EXEC: begin
        bus.ALUOp  = exec_aluop;
        bus.AluSrc = exec_alusrc;
        if (op_reg == OP_BEQ) begin
          bus.PCWrite   = bus.Zero;
          bus.PCSrc     = 1'b1;
          bus.InstrDone = 1'b1;
        end
      end
      S_MEM: begin
        bus.ALUOp     = exec_aluop;
        bus.AluSrc    = exec_alusrc;
        bus.MemReq    = 1'b1;
        bus.IorD      = 1'b1;
        bus.MemWrite  = (op_reg == OP_SW);
        bus.InstrDone = (op_reg == OP_SW) && bus.MemReady;
      end
      S_WB: begin
        bus.ALUOp     = exec_aluop;
        bus.AluSrc    = exec_alusrc;
        bus.RegWrite  = 1'b1;
        bus.InstrDone = 1'b1;
        bus.RegDst    = is_rtype(op_reg);
        bus.MemToReg  = (op_reg == OP_LW);
      end
      S_HALT:  bus.Halted = HALT_EN;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// tb_cpu_sequencer : randomized instruction stream with a queue scoreboard fed
//                    from an instruction-level model of the sequencer. Rev 1.0
// ============================================================================
module tb_cpu_sequencer;
  logic clk = 1'b0;
  logic reset;

  cpu_sequencer_if bus ();
  cpu_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, want, $time);
    end
  endtask

  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_ILL = 5, C_HALT = 6;

  function automatic int cls_of(input logic [3:0] op);
    case (op)
      4'h0, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'hC: return C_R;
      4'h1, 4'h5, 4'hD: return C_I;
      4'h8: return C_LW;
      4'h9: return C_SW;
      4'hF: return C_BEQ;
`ifdef CPU_SEQ_HALT_EN
      4'hE: return C_HALT;
`endif
      default: return C_ILL;
    endcase
  endfunction

  typedef struct {
    int cycles; int sig; int regwrite; int regdst; int memtoreg; int memwr;
    int memrd; int pcwr; int pcsrc; int irwr; int illegal; int aluop; int alusrc;
  } exp_t;

  exp_t sb[$];

  // Expected per-instruction behaviour: visited state list plus side effects.
  function automatic exp_t model(input logic [3:0] op, input int wf, input int wm, input bit z);
    exp_t e;
    int   st[$];
    int   c = cls_of(op);
    e = '{default: 0};
    for (int i = 0; i <= wf; i++) st.push_back(1);
    st.push_back(2);
    if (c == C_R || c == C_I || c == C_LW || c == C_SW || c == C_BEQ) st.push_back(3);
    if (c == C_LW || c == C_SW) for (int i = 0; i <= wm; i++) st.push_back(4);
    if (c == C_R || c == C_I || c == C_LW) st.push_back(5);
    foreach (st[i]) e.sig = e.sig * 8 + st[i];
    case (c)
      C_R:   begin e.cycles = 4; e.regwrite = 1; e.regdst = 1; e.aluop = 2; end
      C_I:   begin e.cycles = 4; e.regwrite = 1; e.aluop = 3; e.alusrc = 1; end
      C_LW:  begin e.cycles = 5; e.regwrite = 1; e.memtoreg = 1; e.memrd = 1; e.alusrc = 1; end
      C_SW:  begin e.cycles = 4; e.memwr = 1; e.alusrc = 1; end
      C_BEQ: begin e.cycles = 3; e.aluop = 1; e.pcsrc = int'(z); end
      C_ILL: begin e.cycles = 2; e.illegal = 1; end
      default: e.cycles = 2;
    endcase
    e.cycles += wf + ((c == C_LW || c == C_SW) ? wm : 0);
    e.pcwr = 1 + e.pcsrc;
    e.irwr = 1;
    return e;
  endfunction

  function automatic logic [15:0] outs();
    return {bus.MemReq, bus.MemWrite, bus.IorD, bus.IRWrite, bus.PCWrite, bus.PCSrc,
            bus.RegWrite, bus.RegDst, bus.MemToReg, bus.AluSrc, bus.ALUOp,
            bus.InstrDone, bus.IllegalOp, bus.Halted, 1'b0};
  endfunction

  // Monitor accumulators for the instruction in flight.
  int a_cyc, a_sig, a_rw, a_rdst, a_mtr, a_mwr, a_mrd, a_pcw, a_pcs, a_irw, a_ill;

  task automatic clear_acc();
    a_cyc = 0; a_sig = 0; a_rw = 0; a_rdst = 0; a_mtr = 0; a_mwr = 0;
    a_mrd = 0; a_pcw = 0; a_pcs = 0; a_irw = 0; a_ill = 0;
  endtask

  initial begin : monitor
    bit   pw, p_we, p_iord;
    exp_t e;
    clear_acc();
    pw = 0; p_we = 0; p_iord = 0;
    forever begin
      @(negedge clk); #2;
      if (reset) begin
        clear_acc();
        sb.delete();
        pw = 0;
      end else if (bus.State == 3'd0) begin
        chk("init_outputs", int'(outs()), 0);
        pw = 0;
      end else begin
        if (pw) begin
          chk("req_hold", int'(bus.MemReq), 1);
          chk("iord_hold", int'(bus.IorD), int'(p_iord));
          chk("we_hold", int'(bus.MemWrite), int'(p_we));
        end
        chk("we_without_req", int'(bus.MemWrite & ~bus.MemReq), 0);
        chk("halted_flag", int'(bus.Halted), int'(bus.State == 3'd6));
        a_cyc++;
        a_sig = a_sig * 8 + int'(bus.State);
        if (bus.RegWrite) begin a_rw++; a_rdst = int'(bus.RegDst); a_mtr = int'(bus.MemToReg); end
        if (bus.MemReq && bus.MemReady && bus.IorD && bus.MemWrite) a_mwr++;
        if (bus.MemReq && bus.MemReady && bus.IorD && !bus.MemWrite) a_mrd++;
        if (bus.PCWrite) a_pcw++;
        if (bus.PCWrite && bus.PCSrc) a_pcs++;
        if (bus.IRWrite) a_irw++;
        if (bus.IllegalOp) a_ill++;
        pw = bus.MemReq & ~bus.MemReady; p_we = bus.MemWrite; p_iord = bus.IorD;
        if (bus.InstrDone) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("cycles", a_cyc, e.cycles);
            chk("state_seq", a_sig, e.sig);
            chk("regwrite", a_rw, e.regwrite);
            chk("regdst", a_rdst, e.regdst);
            chk("memtoreg", a_mtr, e.memtoreg);
            chk("mem_write", a_mwr, e.memwr);
            chk("mem_read", a_mrd, e.memrd);
            chk("pcwrite", a_pcw, e.pcwr);
            chk("pcsrc_taken", a_pcs, e.pcsrc);
            chk("irwrite", a_irw, e.irwr);
            chk("illegal", a_ill, e.illegal);
            chk("aluop", int'(bus.ALUOp), e.aluop);
            chk("alusrc", int'(bus.AluSrc), e.alusrc);
          end
          clear_acc();
        end
      end
    end
  end

  // Memory/IR responder: grants a request after a chosen number of wait cycles.
  task automatic serve(input int waits, input string tag);
    int  waited = 0;
    int  g      = 0;
    bit  acc    = 0;
    while (!acc) begin
      @(negedge clk);
      bus.Opcode = 4'($urandom);
      bus.Zero   = 1'($urandom);
      if (bus.MemReq) begin
        if (waited == waits) begin bus.MemReady = 1'b1; acc = 1; end
        else begin bus.MemReady = 1'b0; waited++; end
      end else begin
        bus.MemReady = 1'($urandom);
      end
      g++;
      if (!acc && g > 100) begin chk(tag, 1, 0); return; end
    end
  endtask

  task automatic run_instr(input logic [3:0] op, input int wf, input int wm, input bit z);
    int c = cls_of(op);
    sb.push_back(model(op, wf, wm, z));
    serve(wf, "fetch_timeout");
    @(negedge clk);
    bus.Opcode = op; bus.MemReady = 1'($urandom); bus.Zero = 1'($urandom);
    if (c == C_BEQ) begin
      @(negedge clk);
      bus.Opcode = 4'($urandom); bus.MemReady = 1'($urandom); bus.Zero = z;
    end else if (c == C_LW || c == C_SW) begin
      serve(wm, "mem_timeout");
    end
  endtask

  task automatic drain();
    int g = 0;
    bus.MemReady = 1'b0;
    while (sb.size() != 0 && g < 50) begin
      @(negedge clk);
      bus.MemReady = 1'b0;
      g++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish, want finish by 500000");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [3:0] op;
    int         g;
    bit         acc;
    reset = 1'b1;
    bus.Opcode = 4'd0; bus.Zero = 1'b0; bus.MemReady = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", int'(bus.State), 0);
    chk("reset_outputs", int'(outs()), 0);
    @(negedge clk);
    reset = 1'b0;

    run_instr(4'h4, 0, 0, 1'b0);
    run_instr(4'h8, 2, 1, 1'b0);
    run_instr(4'hF, 0, 0, 1'b1);
    run_instr(4'hF, 0, 0, 1'b0);
    run_instr(4'h9, 0, 3, 1'b0);
    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom);
`ifdef CPU_SEQ_HALT_EN
      if (op == 4'hE) op = 4'h5;
`endif
      run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
    end
    drain();

    // Abandon a stalled LW data access with an asynchronous reset.
    acc = 0; g = 0;
    while (!acc && g < 50) begin
      @(negedge clk);
      g++;
      if (bus.MemReq) begin bus.MemReady = 1'b1; acc = 1; end
      else bus.MemReady = 1'b0;
    end
    @(negedge clk);
    bus.Opcode = 4'h8; bus.MemReady = 1'b0;
    g = 0;
    while (!(bus.MemReq && bus.IorD) && g < 10) begin
      @(negedge clk);
      bus.MemReady = 1'b0; bus.Opcode = 4'($urandom);
      g++;
    end
    chk("lw_in_mem", int'(bus.MemReq && bus.IorD), 1);
    #1 reset = 1'b1;
    #1;
    chk("midrst_state", int'(bus.State), 0);
    chk("midrst_outputs", int'(outs()), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_state", int'(bus.State), 1);
    chk("post_rst_req", int'(bus.MemReq), 1);
    chk("post_rst_iord", int'(bus.IorD), 0);

    run_instr(4'hE, 0, 0, 1'b0);
`ifdef CPU_SEQ_HALT_EN
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.MemReady = 1'($urandom); bus.Opcode = 4'($urandom);
      #3;
      chk("halt_state", int'(bus.State), 6);
      chk("halt_flag", int'(bus.Halted), 1);
      chk("halt_req", int'(bus.MemReq), 0);
    end
    chk("halt_sb", sb.size(), 0);
`else
    run_instr(4'h4, 1, 0, 1'b0);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
